relu_fc_stage: RTL and testbench
================================

// Module: relu_fc_stage
// PURPOSE
//  Parametrised activation/requantisation stage after an FC accumulator; N_CH lanes per beat.
//  Modes: binarise on sign, ReLU with shift+unsigned saturation, or signed shift+saturation.
//  Adds valid/ready flow control with a skid buffer, frame-level beat counting and out_last tagging.
//  Sits between the FC MAC array output and the next layer's input buffer or classifier.
// PARAMETERS
//  N_CH      4   lanes per beat
//  IN_W      32  signed two's-complement accumulator width per lane
//  OUT_W     8   output width per lane
//  FRAME_LEN 10  accepted beats per frame; must be >= 1
//  SHIFT_W   5   width of cfg_shift
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            synchronous reset, active-low
//  cfg_mode   in   2            00 BIN, 01 RELU_SAT, 10 PASS_SAT, 11 reserved (acts as BIN)
//  cfg_shift  in   SHIFT_W      arithmetic right shift applied before saturation
//  in_valid   in   1            input beat valid
//  in_ready   out  1            stage can accept a beat
//  in_data    in   N_CH*IN_W    lane k in bits [k*IN_W +: IN_W]
//  out_valid  out  1            output beat valid
//  out_ready  in   1            downstream accepts
//  out_data   out  N_CH*OUT_W   lane k in bits [k*OUT_W +: OUT_W]
//  out_last   out  1            final beat of frame
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_last=0, in_ready=0, skid empty,
//    beat_cnt=0, latched mode=BIN, shift=0. in_ready is registered: 1 on first cycle after release.
//  - Accept: in_valid & in_ready. Emit: out_valid & out_ready.
//  - Latency: accepted beat appears on out_* the next cycle when the output register is free.
//  - Output reg + 1-entry skid: accept while out stalled -> beat stored in skid; in_ready registered
//    = ~skid_full_next. Skid drains into output reg on emit. Full throughput with out_ready=1.
//    No beat dropped, duplicated or reordered; out_data/out_last stable while out_valid & ~out_ready.
//  - Frame FSM: IDLE (beat_cnt=0) / IN_FRAME. cfg_mode, cfg_shift sampled only on accept in IDLE
//    and held for the whole frame; changes mid-frame are ignored until next frame.
//  - beat_cnt counts accepted beats 0..FRAME_LEN-1; beat FRAME_LEN-1 tagged last=1, cnt wraps to 0,
//    FSM -> IDLE. FRAME_LEN=1: every beat is last and samples cfg.
//  - Per lane, x signed IN_W, y = x >>> shift (arithmetic, truncating toward -inf):
//    BIN:      out = {(OUT_W-1)'0, ~x[IN_W-1]}  (x>=0 -> 1, including zero)
//    RELU_SAT: x<0 -> 0; else out = min(y, 2^OUT_W-1) unsigned
//    PASS_SAT: out = clamp(y, -2^(OUT_W-1), 2^(OUT_W-1)-1) signed
//    shift >= IN_W: y = 0 for x>=0, -1 for x<0.
//  - Simultaneous accept+emit with skid empty: new beat goes straight to output reg.
//  - Reset mid-frame: all in-flight beats discarded, beat_cnt=0, next accepted beat starts frame.
// STRUCTURE
//  - Package relu_fc_pkg: typedef enum logic[1:0] act_mode_e {ACT_BIN, ACT_RELU_SAT, ACT_PASS_SAT,
//    ACT_RSVD}; frame_state_e {FR_IDLE, FR_IN}; function sat_s/sat_u helpers.
//  - Sub-module relu_fc_lane (combinational, one lane: shift + mode + saturate), N_CH instances via
//    generate; top holds skid, output reg, beat counter, cfg latch, FSM.
// TESTING
//  - BIN, N_CH=4: lanes {-5, 0, 7, 32'h8000_0000} -> out lanes {0,1,1,0}, out_valid 1 cycle later.
//  - RELU_SAT shift=4: {-1, 255<<4, 300<<4, 15} -> {0, 255, 255, 0}.
//  - PASS_SAT shift=0: {-200, 127, 128, -128} -> {-128(8'h80), 127, 127, -128}.
//  - FRAME_LEN=10, continuous in_valid/out_ready: 10 beats back-to-back, out_last only on 10th;
//    cfg_mode changed BIN->RELU_SAT at beat 4 takes effect at beat 11 only.
//  - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 beats held (out+skid),
//    in_ready drops, then out_ready=1 -> beats drain in order, no loss/duplication.
//  - rst_n=0 for 1 cycle at beat 6 -> outputs zeroed, in_ready=0 that cycle; next frame's
//    out_last on its 10th accepted beat.

Source files
------------

// File: rtl/relu_fc_pkg.sv
// Shared types and saturation helpers for the FC activation/requantisation stage.
package relu_fc_pkg;

    typedef enum logic [1:0] {
        ACT_BIN      = 2'b00,
        ACT_RELU_SAT = 2'b01,
        ACT_PASS_SAT = 2'b10,
        ACT_RSVD     = 2'b11
    } act_mode_e;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_IN   = 1'b1
    } frame_state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_HI   = 2'b01,
        SAT_LO   = 2'b10
    } sat_e;

    // Helpers report which clamp applies; the lane builds the OUT_W-wide result.
    function automatic sat_e sat_u(input logic signed [63:0] y, input int unsigned w);
        logic signed [63:0] maxv;
        maxv = (64'sd1 <<< w) - 64'sd1;
        if (y < 64'sd0)
            return SAT_LO;
        else if (y > maxv)
            return SAT_HI;
        else
            return SAT_NONE;
    endfunction

    function automatic sat_e sat_s(input logic signed [63:0] y, input int unsigned w);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -maxv - 64'sd1;
        if (y > maxv)
            return SAT_HI;
        else if (y < minv)
            return SAT_LO;
        else
            return SAT_NONE;
    endfunction

endpackage

// File: rtl/relu_fc_lane.sv
// One lane of activation: arithmetic shift, mode select, saturation. Purely combinational.
import relu_fc_pkg::*;

module relu_fc_lane #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic [IN_W-1:0]    x_i,
    input  logic [1:0]         mode_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [OUT_W-1:0]   y_o
);

    logic signed [IN_W-1:0] x;
    logic signed [IN_W-1:0] y;
    logic signed [63:0]     y_ext;
    sat_e                   sat;

    always_comb begin
        x = $signed(x_i);
        // Shifting by IN_W or more collapses to the sign: 0 or -1.
        if (int'(shift_i) >= IN_W)
            y = x[IN_W-1] ? '1 : '0;
        else
            y = x >>> shift_i;
        y_ext = 64'(y);
        sat   = SAT_NONE;
        y_o   = '0;
        case (act_mode_e'(mode_i))
            ACT_RELU_SAT: begin
                sat = sat_u(y_ext, OUT_W);
                if (x[IN_W-1] || sat == SAT_LO)
                    y_o = '0;
                else if (sat == SAT_HI)
                    y_o = '1;
                else
                    y_o = y[OUT_W-1:0];
            end
            ACT_PASS_SAT: begin
                sat = sat_s(y_ext, OUT_W);
                if (sat == SAT_HI)
                    y_o = {1'b0, {(OUT_W-1){1'b1}}};
                else if (sat == SAT_LO)
                    y_o = {1'b1, {(OUT_W-1){1'b0}}};
                else
                    y_o = y[OUT_W-1:0];
            end
            default: y_o = {{(OUT_W-1){1'b0}}, ~x[IN_W-1]};
        endcase
    end

endmodule

// File: rtl/relu_fc_stage.sv
// Activation stage after the FC accumulator: per-lane requantisation, output register with
// a one-entry skid buffer, frame beat counting and last tagging, per-frame config latch.
import relu_fc_pkg::*;

module relu_fc_stage #(
    parameter int N_CH      = 4,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int FRAME_LEN = 10,
    parameter int SHIFT_W   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [SHIFT_W-1:0]    cfg_shift_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N_CH*IN_W-1:0]  in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N_CH*OUT_W-1:0] out_data_o,
    output logic                  out_last_o
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    frame_state_e            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    act_mode_e               mode_q, mode_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;

    logic                    out_valid_q, out_valid_d;
    logic [N_CH*OUT_W-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [N_CH*OUT_W-1:0]   skid_data_q, skid_data_d;
    logic                    skid_last_q, skid_last_d;
    logic                    in_ready_q, in_ready_d;

    act_mode_e               eff_mode;
    logic [SHIFT_W-1:0]      eff_shift;
    logic [N_CH*OUT_W-1:0]   act_data;
    logic                    act_last;
    logic                    accept;
    logic                    out_free;

    assign accept    = in_valid_i & in_ready_q;
    assign out_free  = ~out_valid_q | out_ready_i;
    assign act_last  = (cnt_q == CNT_W'(FRAME_LEN - 1));
    // The first beat of a frame uses the live config; later beats use the latched copy.
    assign eff_mode  = (state_q == FR_IDLE) ? act_mode_e'(cfg_mode_i) : mode_q;
    assign eff_shift = (state_q == FR_IDLE) ? cfg_shift_i : shift_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        relu_fc_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .x_i     (in_data_i[g*IN_W +: IN_W]),
            .mode_i  (eff_mode),
            .shift_i (eff_shift),
            .y_o     (act_data[g*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        if (accept) begin
            if (state_q == FR_IDLE) begin
                mode_d  = act_mode_e'(cfg_mode_i);
                shift_d = cfg_shift_i;
            end
            if (act_last) begin
                cnt_d   = '0;
                state_d = FR_IDLE;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = FR_IN;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = act_data;
                    skid_last_d = act_last;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = act_data;
                out_last_d  = act_last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = act_data;
            skid_last_d  = act_last;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= FR_IDLE;
            cnt_q        <= '0;
            mode_q       <= ACT_BIN;
            shift_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            shift_q      <= shift_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_relu_fc_stage.sv
// Directed bench for relu_fc_stage: modes, frame tagging, config hold, backpressure, reset.
module tb_relu_fc_stage;

    logic         clk;
    logic         rst_n;
    logic [1:0]   cfg_mode;
    logic [4:0]   cfg_shift;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;

    int n_chk;
    int n_fail;

    localparam logic [1:0] M_BIN  = 2'b00;
    localparam logic [1:0] M_RELU = 2'b01;
    localparam logic [1:0] M_PASS = 2'b10;

    localparam logic [31:0] E_BIN  = 32'h0001_0100;
    localparam logic [31:0] E_RELU = 32'h00FF_FF00;
    localparam logic [31:0] E_PASS = 32'h807F_7F80;

    relu_fc_stage #(
        .N_CH(4), .IN_W(32), .OUT_W(8), .FRAME_LEN(10), .SHIFT_W(5)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cfg_mode_i  (cfg_mode),
        .cfg_shift_i (cfg_shift),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] d3(input int i);
        return pk(32'(i), 32'd127, 32'd128, -32'sd128);
    endfunction

    function automatic logic [31:0] e3(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {8'h80, 8'h7F, 8'h7F, v[7:0]};
    endfunction

    // Called at a negedge; one beat is accepted at the following posedge and checked after it.
    task automatic beat(input logic [127:0] d, input logic [1:0] m, input logic [4:0] s,
                        input logic [31:0] exp, input logic exp_last, input string tag);
        in_valid  = 1'b1;
        in_data   = d;
        cfg_mode  = m;
        cfg_shift = s;
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_dat"}, out_data, exp);
        chk({tag, "_lst"}, out_last, exp_last);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v1, v2, v3;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_mode  = M_BIN;
        cfg_shift = 5'd0;
        v1 = pk(-32'sd5, 32'd0, 32'd7, 32'h8000_0000);
        v2 = pk(-32'sd1, 32'd255 << 4, 32'd300 << 4, 32'd15);
        v3 = pk(-32'sd200, 32'd127, 32'd128, -32'sd128);

        repeat (3) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_lst", out_last, 0);
        chk("rst_rdy", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", in_ready, 1);
        chk("rel_vld", out_valid, 0);

        // Frame 1: BIN; mode switched to RELU from beat 4 must not take effect.
        for (int i = 1; i <= 10; i++)
            beat(v1, (i >= 4) ? M_RELU : M_BIN, 5'd4, E_BIN, i == 10, $sformatf("f1b%0d", i));

        // Frame 2: RELU shift 4; shift dropped to 0 mid-frame is ignored (lane3 stays 0).
        for (int i = 1; i <= 10; i++)
            beat(v2, M_RELU, (i >= 5) ? 5'd0 : 5'd4, E_RELU, i == 10, $sformatf("f2b%0d", i));

        // Frame 3: PASS shift 0, then backpressure in the middle.
        beat(v3, M_PASS, 5'd0, E_PASS, 1'b0, "f3b1");
        beat(d3(2), M_BIN, 5'd3, e3(2), 1'b0, "f3b2");
        out_ready = 1'b0;
        in_data   = d3(3);
        chk("bp_rdy_pre", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_rdy_drop", in_ready, 0);
        chk("bp_vld0", out_valid, 1);
        chk("bp_dat0", out_data, e3(2));
        in_data = d3(4);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold_dat%0d", k), out_data, e3(2));
            chk($sformatf("bp_hold_rdy%0d", k), in_ready, 0);
            chk($sformatf("bp_hold_vld%0d", k), out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_drain_dat3", out_data, e3(3));
        chk("bp_drain_vld3", out_valid, 1);
        chk("bp_drain_rdy", in_ready, 1);
        chk("bp_drain_lst3", out_last, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drain_dat4", out_data, e3(4));
        chk("bp_drain_vld4", out_valid, 1);
        for (int i = 5; i <= 10; i++)
            beat(d3(i), M_BIN, 5'd0, e3(i), i == 10, $sformatf("f3b%0d", i));

        // Frame 4: reset lands on beat 6.
        for (int i = 1; i <= 5; i++)
            beat(v1, M_BIN, 5'd0, E_BIN, 1'b0, $sformatf("f4b%0d", i));
        in_data = v1;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_dat", out_data, 0);
        chk("mrst_lst", out_last, 0);
        chk("mrst_rdy", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_rel_rdy", in_ready, 1);
        chk("mrst_rel_vld", out_valid, 0);

        // Frame 5: fresh frame after reset; last on its 10th beat.
        for (int i = 1; i <= 10; i++)
            beat(v2, M_RELU, 5'd4, E_RELU, i == 10, $sformatf("f5b%0d", i));
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_vld", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
